ahb_matrix_arb_rr: RTL and testbench

AHB_MATRIX_ARB_RR -- requirements
Module: ahb_matrix_arb_rr

---
 rtl/ahb_matrix_pkg.sv | 39 +++
 rtl/ahb_matrix_arb_rr_pick.sv | 43 ++++
 rtl/ahb_matrix_arb_rr.sv | 135 +++++++++++++
 tb/tb_ahb_matrix_arb_rr.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_matrix_pkg.sv
// Shared AHB matrix encodings: HTRANS/HBURST codes and fixed-burst beat counts.
package ahb_matrix_pkg;

   typedef enum logic [1:0] {
      TR_IDLE   = 2'b00,
      TR_BUSY   = 2'b01,
      TR_NONSEQ = 2'b10,
      TR_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HB_SINGLE = 3'b000,
      HB_INCR   = 3'b001,
      HB_WRAP4  = 3'b010,
      HB_INCR4  = 3'b011,
      HB_WRAP8  = 3'b100,
      HB_INCR8  = 3'b101,
      HB_WRAP16 = 3'b110,
      HB_INCR16 = 3'b111
   } hburst_e;

   // Beats still owed after the NONSEQ beat of a fixed-length burst
   localparam logic [3:0] BEATS_NONE    = 4'd0;
   localparam logic [3:0] BEATS_LEFT_4  = 4'd3;
   localparam logic [3:0] BEATS_LEFT_8  = 4'd7;
   localparam logic [3:0] BEATS_LEFT_16 = 4'd15;

   function automatic logic [3:0] burst_beats_left(input logic [2:0] hburst);
      logic [3:0] beats;
      case (hburst_e'(hburst))
         HB_WRAP4,  HB_INCR4:  beats = BEATS_LEFT_4;
         HB_WRAP8,  HB_INCR8:  beats = BEATS_LEFT_8;
         HB_WRAP16, HB_INCR16: beats = BEATS_LEFT_16;
         default:              beats = BEATS_NONE;
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/ahb_matrix_arb_rr_pick.sv
// Rotating priority encoder: first requester at or after start_idx (wrapping) wins.
module ahb_matrix_arb_rr_pick
   import ahb_matrix_pkg::*;
#(
   parameter int NUM_PORTS = 3,
   parameter int PORT_W    = 2
)
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PORT_W-1:0]    start_idx,
   output logic [PORT_W-1:0]    winner,
   output logic                 valid
);

   localparam logic [PORT_W:0] PORTS_W = (PORT_W+1)'(NUM_PORTS);

   logic [PORT_W:0]   sum_s;
   logic [PORT_W-1:0] idx_s;

   // Walk offsets from farthest to nearest so the nearest requester is the last write
   always_comb begin
      winner = start_idx;
      valid  = 1'b0;
      sum_s  = '0;
      idx_s  = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         sum_s = {1'b0, start_idx} + (PORT_W+1)'(i);
         if (sum_s >= PORTS_W) begin
            sum_s = sum_s - PORTS_W;
         end else begin
            sum_s = sum_s;
         end
         idx_s = sum_s[PORT_W-1:0];
         if (req[idx_s]) begin
            winner = idx_s;
            valid  = 1'b1;
         end else begin
            valid  = valid;
         end
      end
   end

endmodule

// File: rtl/ahb_matrix_arb_rr.sv
// Round-robin output-stage arbiter with fixed/undefined burst hold.
// Optional master lock hold enabled by defining AHB_MATRIX_ARB_LOCK_EN.
module ahb_matrix_arb_rr
   import ahb_matrix_pkg::*;
#(
   parameter int NUM_PORTS = 3,
   parameter int PORT_W    = 2
)
(
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic [NUM_PORTS-1:0] req_port,
   input  logic                 HREADYM,
   input  logic                 HSELM,
   input  logic [1:0]           HTRANSM,
   input  logic [2:0]           HBURSTM,
   input  logic                 HMASTLOCKM,
   output logic [PORT_W-1:0]    addr_in_port,
   output logic                 no_port
);

   localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

   logic [PORT_W-1:0] grant_r;
   logic [PORT_W-1:0] grant_nxt_s;
   logic [PORT_W-1:0] start_s;
   logic [PORT_W-1:0] winner_s;
   logic              no_port_r;
   logic              no_port_nxt_s;
   logic              pick_valid_s;
   logic [3:0]        cnt_r;
   logic [3:0]        cnt_nxt_s;
   logic              accept_s;
   logic              holder_req_s;
   logic              burst_hold_s;
   logic              hold_s;

   assign accept_s     = HSELM & ~no_port_r;
   assign holder_req_s = ~no_port_r & req_port[grant_r];
   assign start_s      = (grant_r == LAST_PORT) ? '0 : grant_r + PORT_W'(1);

   ahb_matrix_arb_rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .PORT_W    (PORT_W)
   ) u_pick (
      .req       (req_port),
      .start_idx (start_s),
      .winner    (winner_s),
      .valid     (pick_valid_s)
   );

   // Burst hold decision and beat counter next state
   always_comb begin
      cnt_nxt_s    = cnt_r;
      burst_hold_s = 1'b0;
      if (!holder_req_s) begin
         cnt_nxt_s = BEATS_NONE;
      end else if (accept_s) begin
         if (cnt_r != BEATS_NONE) begin
            case (htrans_e'(HTRANSM))
               TR_SEQ: begin
                  cnt_nxt_s    = cnt_r - 4'd1;
                  burst_hold_s = (cnt_r != 4'd1);
               end
               TR_BUSY: burst_hold_s = 1'b1;
               default: cnt_nxt_s    = BEATS_NONE;
            endcase
         end else begin
            case (htrans_e'(HTRANSM))
               TR_NONSEQ: begin
                  cnt_nxt_s    = burst_beats_left(HBURSTM);
                  burst_hold_s = (cnt_nxt_s != BEATS_NONE);
               end
               TR_SEQ, TR_BUSY: burst_hold_s = (hburst_e'(HBURSTM) == HB_INCR);
               default:         burst_hold_s = 1'b0;
            endcase
         end
      end else begin
         burst_hold_s = (cnt_r != BEATS_NONE);
      end
   end

`ifdef AHB_MATRIX_ARB_LOCK_EN
   logic lock_r;
   logic lock_nxt_s;

   assign lock_nxt_s = accept_s ? HMASTLOCKM : lock_r;
   assign hold_s     = burst_hold_s | lock_nxt_s;

   // Lock flag follows HMASTLOCKM of each accepted transfer
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         lock_r <= 1'b0;
      end else if (HREADYM) begin
         lock_r <= lock_nxt_s;
      end
   end
`else
   logic lock_unused_s;

   assign lock_unused_s = HMASTLOCKM;
   assign hold_s        = burst_hold_s;
`endif

   // Grant next state: hold, rotate to next requester, or park with no port
   always_comb begin
      grant_nxt_s   = grant_r;
      no_port_nxt_s = no_port_r;
      if (hold_s) begin
         no_port_nxt_s = 1'b0;
      end else if (pick_valid_s) begin
         grant_nxt_s   = winner_s;
         no_port_nxt_s = 1'b0;
      end else begin
         no_port_nxt_s = 1'b1;
      end
   end

   // Grant and beat counter registers advance only on ready cycles
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         grant_r   <= '0;
         no_port_r <= 1'b1;
         cnt_r     <= BEATS_NONE;
      end else if (HREADYM) begin
         grant_r   <= grant_nxt_s;
         no_port_r <= no_port_nxt_s;
         cnt_r     <= cnt_nxt_s;
      end
   end

   assign addr_in_port = grant_r;
   assign no_port      = no_port_r;

endmodule

// File: tb/tb_ahb_matrix_arb_rr.sv
// Self-checking bench for ahb_matrix_arb_rr: directed scenarios plus random traffic
// compared every cycle against a behavioural arbitration model.
module tb_ahb_matrix_arb_rr;
   import ahb_matrix_pkg::*;

   localparam int N = 3;

   logic         HCLK = 1'b0;
   logic         HRESETn = 1'b0;
   logic [N-1:0] req_port;
   logic         HREADYM;
   logic         HSELM;
   logic [1:0]   HTRANSM;
   logic [2:0]   HBURSTM;
   logic         HMASTLOCKM;
   logic [1:0]   addr_in_port;
   logic         no_port;

   int checks = 0;
   int failures = 0;

   always #5 HCLK = ~HCLK;

   ahb_matrix_arb_rr #(.NUM_PORTS(N), .PORT_W(2)) dut (
      .HCLK         (HCLK),
      .HRESETn      (HRESETn),
      .req_port     (req_port),
      .HREADYM      (HREADYM),
      .HSELM        (HSELM),
      .HTRANSM      (HTRANSM),
      .HBURSTM      (HBURSTM),
      .HMASTLOCKM   (HMASTLOCKM),
      .addr_in_port (addr_in_port),
      .no_port      (no_port)
   );

   // Behavioural model: who owns the output, and how many beats the owner still owes
   typedef struct packed {
      int grant;
      bit none;
      int left;
      bit lock;
   } model_t;

   model_t m;

   function automatic bit req_at(int p);
      return ((req_port >> p) & 3'b001) != 3'b000;
   endfunction

   function automatic int burst_len(logic [2:0] b);
      case (b)
         3'd2, 3'd3: return 4;
         3'd4, 3'd5: return 8;
         3'd6, 3'd7: return 16;
         default:    return 1;
      endcase
   endfunction

   function automatic model_t model_next(model_t s);
      model_t n;
      bit keep;
      bit owner_req;
      bit acc;
      bit found;
      int pos;
      n = s;
      keep = 1'b0;
      owner_req = !s.none && req_at(s.grant);
      acc = HSELM && !s.none;
      if (!owner_req) begin
         n.left = 0;
      end else if (acc) begin
         if (s.left > 0) begin
            if (HTRANSM == TR_SEQ) begin
               n.left = s.left - 1;
               keep = n.left > 0;
            end else if (HTRANSM == TR_BUSY) begin
               keep = 1'b1;
            end else begin
               n.left = 0;
            end
         end else if (HTRANSM == TR_NONSEQ) begin
            n.left = burst_len(HBURSTM) - 1;
            keep = n.left > 0;
         end else begin
            keep = (HBURSTM == HB_INCR) && (HTRANSM == TR_SEQ || HTRANSM == TR_BUSY);
         end
      end else begin
         keep = s.left > 0;
      end
`ifdef AHB_MATRIX_ARB_LOCK_EN
      if (acc) n.lock = HMASTLOCKM;
      keep = keep || n.lock;
`endif
      if (keep) begin
         n.none = 1'b0;
      end else begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            pos = (s.grant + k) % N;
            if (!found && req_at(pos)) begin
               found = 1'b1;
               n.grant = pos;
            end
         end
         n.none = !found;
      end
      return n;
   endfunction

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         m <= '{grant: 0, none: 1'b1, left: 0, lock: 1'b0};
      end else if (HREADYM) begin
         m <= model_next(m);
      end
   end

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
      end
   endtask

   // Advance one edge, then compare DUT against the model
   task automatic tick();
      @(posedge HCLK);
      #1;
      chk("cycle_grant", int'(addr_in_port), m.grant);
      chk("cycle_no_port", int'(no_port), int'(m.none));
   endtask

   task automatic expect_g(input string nm, input int g, input int nop);
      chk({nm, "_grant"}, int'(addr_in_port), g);
      chk({nm, "_no_port"}, int'(no_port), nop);
      chk({nm, "_model"}, m.grant, g);
   endtask

   task automatic drv(input logic [2:0] r, input logic rdy, input logic [1:0] tr,
                      input logic [2:0] b, input logic lk);
      req_port   = r;
      HREADYM    = rdy;
      HSELM      = 1'b1;
      HTRANSM    = tr;
      HBURSTM    = b;
      HMASTLOCKM = lk;
   endtask

   initial begin
      drv(3'b000, 1'b1, TR_IDLE, HB_SINGLE, 1'b0);
      HSELM = 1'b0;
      repeat (2) tick();
      expect_g("reset", 0, 1);
      HRESETn = 1'b1;
      tick();
      expect_g("idle_after_reset", 0, 1);

      // Round-robin over single transfers
      drv(3'b111, 1'b1, TR_NONSEQ, HB_SINGLE, 1'b0);
      tick(); expect_g("rr_a", 1, 0);
      tick(); expect_g("rr_b", 2, 0);
      tick(); expect_g("rr_c", 0, 0);
      tick(); expect_g("rr_d", 1, 0);
      tick(); expect_g("rr_e", 2, 0);

      // Port 2 INCR4
      drv(3'b111, 1'b1, TR_NONSEQ, HB_INCR4, 1'b0);
      tick(); expect_g("incr4_b1", 2, 0);
      HTRANSM = TR_SEQ;
      tick(); expect_g("incr4_b2", 2, 0);
      tick(); expect_g("incr4_b3", 2, 0);
      tick(); expect_g("incr4_b4", 0, 0);

      // Port 0 INCR8 with three wait states while holder drops request
      drv(3'b111, 1'b1, TR_NONSEQ, HB_INCR8, 1'b0);
      tick(); expect_g("incr8_b1", 0, 0);
      HTRANSM = TR_SEQ;
      tick(); tick(); expect_g("incr8_b3", 0, 0);
      HREADYM = 1'b0;
      req_port = 3'b110;
      repeat (3) begin tick(); expect_g("incr8_wait", 0, 0); end
      req_port = 3'b111;
      HREADYM = 1'b1;
      repeat (4) begin tick(); expect_g("incr8_mid", 0, 0); end
      tick(); expect_g("incr8_b8", 1, 0);

      // Port 1 INCR16 terminated by IDLE after five beats
      drv(3'b111, 1'b1, TR_NONSEQ, HB_INCR16, 1'b0);
      tick();
      HTRANSM = TR_SEQ;
      repeat (4) tick();
      expect_g("incr16_b5", 1, 0);
      HTRANSM = TR_IDLE;
      tick(); expect_g("incr16_idle", 2, 0);

      // SEQ with empty counter does not hold a fixed burst
      HTRANSM = TR_SEQ;
      HBURSTM = HB_INCR4;
      tick(); expect_g("seq_cnt0", 0, 0);

      // Sole requester keeps grant; no requesters parks the pointer
      drv(3'b001, 1'b1, TR_NONSEQ, HB_SINGLE, 1'b0);
      tick(); expect_g("sole_a", 0, 0);
      tick(); expect_g("sole_b", 0, 0);
      req_port = 3'b000;
      tick(); expect_g("no_req", 0, 1);
      req_port = 3'b010;
      tick(); expect_g("after_no_req", 1, 0);

      // Holder drops request mid-burst
      drv(3'b111, 1'b1, TR_NONSEQ, HB_INCR4, 1'b0);
      tick(); expect_g("drop_b1", 1, 0);
      req_port = 3'b101;
      HTRANSM = TR_SEQ;
      tick(); expect_g("drop", 2, 0);

      // Undefined-length INCR
      drv(3'b111, 1'b1, TR_SEQ, HB_INCR, 1'b0);
      tick(); expect_g("incr_seq", 2, 0);
      HTRANSM = TR_BUSY;
      tick(); expect_g("incr_busy", 2, 0);
      HTRANSM = TR_IDLE;
      tick(); expect_g("incr_idle", 0, 0);

      // Locked singles from port 0
      drv(3'b111, 1'b1, TR_NONSEQ, HB_SINGLE, 1'b1);
`ifdef AHB_MATRIX_ARB_LOCK_EN
      tick(); expect_g("lock_a", 0, 0);
      tick(); expect_g("lock_b", 0, 0);
      tick(); expect_g("lock_c", 0, 0);
`else
      tick(); expect_g("lock_a", 1, 0);
      tick(); expect_g("lock_b", 2, 0);
      tick(); expect_g("lock_c", 0, 0);
`endif
      HMASTLOCKM = 1'b0;
      tick(); expect_g("unlock", 1, 0);

      // Reset in the middle of an INCR8
      drv(3'b111, 1'b1, TR_NONSEQ, HB_INCR8, 1'b0);
      tick();
      HTRANSM = TR_SEQ;
      tick(); tick(); expect_g("rst_b3", 1, 0);
      HRESETn = 1'b0;
      #1;
      expect_g("rst_async", 0, 1);
      tick();
      HRESETn = 1'b1;
      HTRANSM = TR_NONSEQ;
      HBURSTM = HB_SINGLE;
      tick(); expect_g("post_rst_a", 1, 0);
      HTRANSM = TR_SEQ;
      tick(); expect_g("post_rst_b", 2, 0);

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         req_port   = 3'($urandom_range(0, 7));
         HREADYM    = ($urandom_range(0, 3) != 0);
         HSELM      = ($urandom_range(0, 7) != 0);
         HTRANSM    = 2'($urandom_range(0, 3));
         HBURSTM    = 3'($urandom_range(0, 7));
         HMASTLOCKM = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 499) == 0) HRESETn = 1'b0;
         else HRESETn = 1'b1;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
